uart_mem_loader: RTL and testbench

//  Consumes bytes from the UART receiver (character/dataReady) and loads them into processor memory.

---
 rtl/uart_mem_loader_pkg.sv | 16 +
 rtl/uart_mem_loader_pulse_sync.sv | 28 ++
 rtl/uart_mem_loader.sv | 160 ++++++++++++++++
 tb/tb_uart_mem_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART memory loader: FSM state encoding and
// default frame/timeout constants.
package uart_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
  localparam int         DEF_TIMEOUT_CYC = 104160;

endpackage

// File: rtl/uart_mem_loader_pulse_sync.sv
// Two-flop synchronizer followed by a rising-edge detector; one pulse per
// rising edge of async_in regardless of how long it stays high.
module pulse_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign pulse_out = r_sync & ~r_prev;

endmodule

// File: rtl/uart_mem_loader.sv
// Parses SYNC/LEN/payload/CHK frames from the UART receiver and writes the
// payload, packed little-endian into words, to memory from address 0.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         WORD_BYTES  = 2,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(TIMEOUT_CYC);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_len_hi;
  logic [15:0]         r_rem;
  logic [LANE_W-1:0]   r_lane;
  logic [DATA_W-1:0]   r_word;
  logic [ADDR_W:0]     r_addr;
  logic [7:0]          r_csum;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_done;
  logic                r_err;

  logic                w_acc;
  logic [15:0]         w_len;
  logic [15:0]         w_rem_dec;
  logic [DATA_W-1:0]   w_word_next;
  logic                w_word_done;
  logic                w_busy;
  logic                w_sync_acc;
  logic                w_pay_acc;
  logic                w_wr_need;
  logic                w_ovf;
  logic                w_tmo;
  logic                w_set_err;
  logic                w_set_done;

  pulse_sync u_pulse_sync (
    .clock     (clock),
    .reset     (reset),
    .async_in  (rx_ready),
    .pulse_out (w_acc)
  );

  assign w_len       = {r_len_hi, rx_data};
  assign w_rem_dec   = r_rem - 16'd1;
  assign w_word_done = (r_lane == LAST_LANE) || (w_rem_dec == 16'd0);
  // Lane 0 starts a fresh word so a short final word has zero upper lanes.
  assign w_word_next = ((r_lane == '0) ? '0 : r_word) |
                       (DATA_W'(rx_data) << (8 * int'(r_lane)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_acc && rx_data == SYNC_BYTE) w_next = ST_LEN_HI;
      ST_LEN_HI:  if (w_acc) w_next = ST_LEN_LO;
      ST_LEN_LO:  if (w_acc) w_next = (w_len == 16'd0) ? ST_CHECK : ST_PAYLOAD;
      ST_PAYLOAD: if (w_acc) begin
                    if (w_ovf)                    w_next = ST_IDLE;
                    else if (w_rem_dec == 16'd0)  w_next = ST_CHECK;
                  end
      ST_CHECK:   if (w_acc) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (w_tmo) w_next = ST_IDLE;
  end

  always_comb begin
    w_busy     = (r_state != ST_IDLE);
    w_sync_acc = (r_state == ST_IDLE) && w_acc && (rx_data == SYNC_BYTE);
    w_pay_acc  = (r_state == ST_PAYLOAD) && w_acc;
    w_wr_need  = w_pay_acc && w_word_done;
    w_ovf      = w_wr_need && (r_addr == ADDR_LIMIT);
    // An accept landing on the timeout cycle still wins.
    w_tmo      = w_busy && !w_acc && (r_tmo == TMO_LIMIT);
    w_set_done = (r_state == ST_CHECK) && w_acc && (rx_data == r_csum);
    w_set_err  = w_ovf || w_tmo ||
                 ((r_state == ST_CHECK) && w_acc && (rx_data != r_csum));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len_hi    <= '0;
      r_rem       <= '0;
      r_lane      <= '0;
      r_word      <= '0;
      r_addr      <= '0;
      r_csum      <= '0;
      r_tmo       <= '0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= w_set_done;
      if (w_sync_acc)     r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;

      if (!w_busy || w_acc)       r_tmo <= '0;
      else if (r_tmo != TMO_LIMIT) r_tmo <= r_tmo + TMO_W'(1);

      if (w_sync_acc) begin
        r_csum <= '0;
        r_addr <= '0;
        r_lane <= '0;
      end
      if (r_state == ST_LEN_HI && w_acc) r_len_hi <= rx_data;
      if (r_state == ST_LEN_LO && w_acc) r_rem    <= w_len;

      if (w_pay_acc) begin
        r_csum <= r_csum + rx_data;
        r_rem  <= w_rem_dec;
        r_word <= w_word_next;
        r_lane <= w_word_done ? '0 : r_lane + LANE_W'(1);
        if (w_wr_need && !w_ovf) begin
          r_we        <= 1'b1;
          r_mem_addr  <= r_addr[ADDR_W-1:0];
          r_mem_wdata <= w_word_next;
          r_addr      <= r_addr + (ADDR_W+1)'(1);
        end
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = w_busy;
  assign load_done = r_done;
  assign load_err  = r_err;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: directed frame table, cycle-exact corner
// sequences, and random byte streams checked against a frame-level model.
module tb_uart_mem_loader;

  localparam int         ADDR_W = 2;
  localparam int         WB     = 2;
  localparam int         TMO    = 300;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [8*WB-1:0]   mem_wdata;
  logic              busy;
  logic              load_done;
  logic              load_err;

  uart_mem_loader #(
    .ADDR_W(ADDR_W), .WORD_BYTES(WB), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_q[$];
  int          done_cnt;

  always @(negedge clock) begin
    if (!reset && mem_we)    wr_q.push_back({16'(mem_addr), mem_wdata});
    if (!reset && load_done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clock);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clock);
    rx_ready = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  logic [3:0]  we_s, done_s, err_s, busy_s;
  logic [31:0] wr_s;

  // Raise rx_ready and record outputs on the next four falling edges.
  task automatic raise_watch(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) rx_ready = 1'b0;
      we_s[i]   = mem_we;
      done_s[i] = load_done;
      err_s[i]  = load_err;
      busy_s[i] = busy;
      if (i == 2) wr_s = {16'(mem_addr), mem_wdata};
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic clear_obs();
    wr_q.delete();
    done_cnt = 0;
  endtask

  task automatic compare_run(input string tag, input logic [31:0] exp_wr[$],
                             input int exp_done, input logic exp_err);
    check({tag, ".nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), wr_q[i], exp_wr[i]);
    check({tag, ".done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, ".err"}, 32'(load_err), 32'(exp_err));
    check({tag, ".busy"}, 32'(busy), 32'(0));
  endtask

  typedef struct {
    logic [127:0] bytes;
    int           n;
    int           hold;
    int           nwr;
    logic [159:0] wrs;
    int           done;
    logic         err;
  } vec_t;

  vec_t tbl[10];

  // Frame-level reference: scans the byte stream for frames and derives writes.
  logic [7:0]  stim_q[$];
  logic [31:0] exp_q[$];
  int          m_done;
  logic        m_err = 1'b0;

  task automatic model_run();
    int i, n, len, base, w;
    logic [7:0]  sum;
    logic [15:0] word;
    bit aborted;
    i = 0;
    n = stim_q.size();
    exp_q.delete();
    m_done = 0;
    while (i < n) begin
      if (stim_q[i] != SYNC) begin i++; continue; end
      m_err = 1'b0;
      if (i + 2 >= n) begin m_err = 1'b1; break; end
      len = {stim_q[i+1], stim_q[i+2]};
      base = i + 3;
      sum = 8'h00;
      aborted = 1'b0;
      for (int k = 0; k < len; k++) begin
        if (base + k >= n) begin m_err = 1'b1; aborted = 1'b1; i = n; break; end
        sum += stim_q[base+k];
        if ((k % WB == WB - 1) || (k == len - 1)) begin
          w = k / WB;
          if (w >= (1 << ADDR_W)) begin
            m_err = 1'b1; aborted = 1'b1; i = base + k + 1; break;
          end
          word = 16'h0000;
          for (int j = w * WB; j <= k; j++)
            word |= 16'(stim_q[base+j]) << (8 * (j - w * WB));
          exp_q.push_back({16'(w), word});
        end
      end
      if (aborted) continue;
      if (base + len >= n) begin m_err = 1'b1; break; end
      if (stim_q[base+len] == sum) m_done++;
      else                         m_err = 1'b1;
      i = base + len + 1;
    end
  endtask

  initial begin
    logic [31:0] ew[$];
    vec_t v;

    tbl[0] = '{128'hA5000411223344AA_0000000000000000, 8, 1, 2,
               160'h0000_2211_0001_4433_0000_0000_0000_0000_0000_0000, 1, 1'b0};
    tbl[1] = '{128'hA50003010203_06_000000000000000000, 7, 5, 2,
               160'h0000_0201_0001_0003_0000_0000_0000_0000_0000_0000, 1, 1'b0};
    tbl[2] = '{128'hA50003010203_07_000000000000000000, 7, 1, 2,
               160'h0000_0201_0001_0003_0000_0000_0000_0000_0000_0000, 0, 1'b1};
    tbl[3] = '{128'hA5000210200000000000000000000000, 6, 2, 1,
               160'h0000_2010_0000_0000_0000_0000_0000_0000_0000_0000, 0, 1'b1};
    tbl[4] = '{128'hA5000411223344AA_0000000000000000, 8, 3, 2,
               160'h0000_2211_0001_4433_0000_0000_0000_0000_0000_0000, 1, 1'b0};
    tbl[5] = '{128'hA5000411_000000000000000000000000, 4, 1, 0, 160'h0, 0, 1'b1};
    tbl[6] = '{128'h00FFA5000000_00000000000000000000, 6, 1, 0, 160'h0, 1, 1'b0};
    tbl[7] = '{128'hA5000A0102030405060708090A370000, 14, 1, 4,
               160'h0000_0201_0001_0403_0002_0605_0003_0807_0000_0000, 0, 1'b1};
    tbl[8] = '{128'hA5000000_000000000000000000000000, 4, 1, 0, 160'h0, 1, 1'b0};
    tbl[9] = '{128'hA50008010203040506070824_00000000, 12, 1, 4,
               160'h0000_0201_0001_0403_0002_0605_0003_0807_0000_0000, 1, 1'b0};

    repeat (3) @(negedge clock);
    check("reset.outputs", {26'b0, mem_we, |mem_addr, |mem_wdata, busy, load_done, load_err}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int t = 0; t < 10; t++) begin
      v = tbl[t];
      clear_obs();
      for (int k = 0; k < v.n; k++) send_byte(v.bytes[127-8*k -: 8], v.hold);
      repeat (TMO + 20) @(negedge clock);
      ew.delete();
      for (int k = 0; k < v.nwr; k++) ew.push_back(v.wrs[159-32*k -: 32]);
      compare_run($sformatf("vec%0d", t), ew, v.done, v.err);
    end

    // Write and done strobes land one cycle after the accepting edge.
    clear_obs();
    send_byte(SYNC, 1); send_byte(8'h00, 1); send_byte(8'h01, 1);
    raise_watch(8'h5A);
    check("lat.we", 32'(we_s), 32'b0100);
    check("lat.wr", wr_s, 32'h0000_005A);
    raise_watch(8'h5A);
    check("lat.done", 32'(done_s), 32'b0100);

    // Sticky error clears exactly on the next SYNC accept.
    send_byte(SYNC, 1); send_byte(8'h00, 1); send_byte(8'h01, 1);
    send_byte(8'h10, 1); send_byte(8'h11, 1);
    check("errclr.set", 32'(load_err), 32'h1);
    raise_watch(SYNC);
    check("errclr.err", 32'(err_s), 32'b0011);
    check("errclr.busy", 32'(busy_s[2]), 32'h1);
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    check("errclr.after", {30'b0, load_err, busy}, 32'h0);

    // Asynchronous reset in the middle of a payload.
    clear_obs();
    send_byte(SYNC, 1); send_byte(8'h00, 1); send_byte(8'h04, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1);
    check("rst.pre", {15'b0, busy, mem_wdata}, 32'h0001_2211);
    #2 reset = 1'b1;
    #1 check("rst.outputs", {26'b0, mem_we, |mem_addr, |mem_wdata, busy, load_done, load_err}, 32'h0);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    clear_obs();
    send_byte(SYNC, 1); send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_byte(8'h33, 1); send_byte(8'h44, 1); send_byte(8'h77, 1);
    repeat (10) @(negedge clock);
    ew.delete(); ew.push_back(32'h0000_4433);
    compare_run("rst.post", ew, 1, 1'b0);
    m_err = 1'b0;

    for (int r = 0; r < 30; r++) begin
      int nstray, len, hold;
      logic [7:0] b, sum;
      stim_q.delete();
      nstray = $urandom_range(0, 2);
      for (int k = 0; k < nstray; k++) begin
        b = 8'($urandom_range(0, 255));
        stim_q.push_back(b == SYNC ? 8'h00 : b);
      end
      len = $urandom_range(0, 11);
      stim_q.push_back(SYNC); stim_q.push_back(8'h00); stim_q.push_back(8'(len));
      sum = 8'h00;
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom_range(0, 255));
        sum += b;
        stim_q.push_back(b);
      end
      stim_q.push_back(($urandom_range(0, 3) != 0) ? sum : 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) begin
        int drop = $urandom_range(1, stim_q.size() - 1);
        for (int k = 0; k < drop; k++) void'(stim_q.pop_back());
      end
      model_run();
      clear_obs();
      hold = $urandom_range(1, 4);
      foreach (stim_q[k]) send_byte(stim_q[k], hold);
      repeat (TMO + 20) @(negedge clock);
      compare_run($sformatf("rnd%0d", r), exp_q, m_done, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
